multiplier_pipe: RTL and testbench
==================================

# multiplier_pipe

Parametrised, pipelined integer multiplier for the RISC5 execute stage. Computes a full-width signed or unsigned product of two WIDTH-bit operands over a configurable number of clock cycles, stalling the CPU through the same run/stall handshake the single-cycle multiplier uses. At LATENCY=1 it is cycle-equivalent to the existing single-cycle unit. Larger LATENCY values let the product be split across register stages to meet faster clock targets.

## Interface
Parameters:
- WIDTH, 32, operand width in bits (8..64)
- LATENCY, 3, cycles from operation start to valid product (1..8)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- run  input  1  multiply requested by decoder; held high while stall is high
- u  input  1  1 = unsigned, 0 = signed two's complement; sampled with operands
- x  input  WIDTH  multiplicand
- y  input  WIDTH  multiplier
- stall  output  1  combinational; high while the product is not yet valid
- z  output  2*WIDTH  registered product, held until the next operation completes

## Operation
- States:
  - IDLE: no operation in progress.
  - BUSY: a multiply is in flight; a down-counter cnt tracks remaining cycles.
  - DONE: product valid for exactly one cycle.
- IDLE & run:
  - Start an operation. This is cycle 0.
  - Capture x, y, u into operand registers at the end of cycle 0. Later changes to x/y/u are ignored.
  - Load cnt = LATENCY-1 and go to BUSY. With LATENCY=1, go directly to DONE.
- BUSY:
  - Decrement cnt each cycle.
  - When cnt reaches 0, z is loaded with the product and the FSM goes to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - If run is still high in the following cycle, it is a new, back-to-back operation that starts its own cycle 0. No operation is ever skipped.
- stall = run & (state != DONE).
  - High in IDLE while run is high.
  - High for the whole of BUSY.
  - Low in DONE.
- Abort: if run drops while in BUSY, return to IDLE next cycle. z is not updated and the in-flight result is discarded.
- Arithmetic:
  - Signed mode: operands are sign-extended to 2*WIDTH.
  - Unsigned mode: operands are zero-extended to 2*WIDTH.
  - z is the exact 2*WIDTH-bit product, with no truncation or saturation.
- Pipelining:
  - Operands are split into high and low halves, giving four partial products in the first stage.
  - Summation is distributed over the remaining LATENCY-1 stages.
  - Only the final result matters to verification. Internal staging is free provided latency and stall behaviour are exact.
- Reset (rst low, at any time, including mid-operation): state = IDLE, cnt = 0, operand registers = 0, z = 0. stall then follows run & (state != DONE), so it is high if run is high.

## Timing
- Operation starts in cycle 0 (run high, FSM in IDLE).
- stall is high in cycles 0..LATENCY-1 and low in cycle LATENCY.
- z holds the new product from cycle LATENCY onward and is unchanged until the next completion.
- LATENCY=1: stall is high in cycle 0 only, and z is valid in cycle 1. This matches the legacy single-cycle unit.
- Back-to-back operations:
  - Second operation's cycle 0 = first operation's cycle LATENCY+1.
  - Per-operation throughput: LATENCY+1 cycles.
- stall has a combinational path from run only. There is no path from x, y or u to stall.
- z is driven directly from a register, with no combinational path from inputs.

## Test plan
- WIDTH=32, LATENCY=3, u=1, x=0xFFFFFFFF, y=2, run held high:
  - stall high in cycles 0–2, low in cycle 3.
  - z = 0x00000001_FFFFFFFE from cycle 3.
- Same operands with u=0:
  - z = 0xFFFFFFFF_FFFFFFFE.
  - Corner case x=y=0x80000000 signed gives z = 0x40000000_00000000.
- Operand stability: change x to 0 in cycle 1 of an operation with x=7, y=6. Result must still be z=42 in cycle 3.
- Back-to-back: run high continuously, 5×3 then 4×4.
  - z=15 in cycle 3; stall high in cycles 4–6.
  - z=16 in cycle 7.
- Abort: start 9×9, drop run in cycle 1.
  - FSM in IDLE by cycle 2; z keeps its previous value.
  - A new 2×3 then completes normally with z=6.
- Reset mid-operation: assert rst low during cycle 1 of 9×9.
  - z=0 and stall=0 immediately (run low).
  - After release, 3×3 completes in exactly LATENCY cycles with z=9.
  - Repeat the 3×3 run with LATENCY=1: stall is high for one cycle only.

Source files
------------

// File: rtl/multiplier_pipe.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier with run/stall handshake.
// Result lands in z LATENCY cycles after the operation starts and is held until the next completion.
module multiplier_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 u,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 stall,
  output logic [2*WIDTH-1:0]   z
);

  localparam int unsigned P  = 2 * WIDTH;
  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned HW = WIDTH + 1 - H;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            start, load;

  logic [WIDTH-1:0] xs, ys;
  logic             us;
  logic [WIDTH:0]   ex, ey;
  logic [P-1:0]     xh, xl, yh, yl;
  logic [P-1:0]     pp_c [4];
  logic [P-1:0]     prod;

  // Operands carry one extra bit (sign or zero) so the high half is always a signed quantity.
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic uns);
    return {~uns & v[WIDTH-1], v};
  endfunction

  function automatic logic [P-1:0] hi_part(input logic [WIDTH:0] e);
    return {{(P-HW){e[WIDTH]}}, e[WIDTH:H]};
  endfunction

  function automatic logic [P-1:0] lo_part(input logic [WIDTH:0] e);
    return {{(P-H){1'b0}}, e[H-1:0]};
  endfunction

  function automatic logic [P-1:0] sum_pp(input logic [P-1:0] hh, hl, lh, ll);
    return (hh << (2 * H)) + ((hl + lh) << H) + ll;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (run) begin
        cnt_next   = CW'(LATENCY - 1);
        state_next = (LATENCY == 1) ? DONE : BUSY;
      end
      BUSY: if (!run) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = run & (state != DONE);
    start = (state == IDLE) & run;
    load  = (LATENCY == 1) ? start : ((state == BUSY) & run & (cnt == CW'(1)));
  end

  // Single-cycle variant multiplies straight from the ports; otherwise from captured operands.
  if (LATENCY == 1) begin : g_direct
    assign xs = x;
    assign ys = y;
    assign us = u;
  end else begin : g_capture
    logic [WIDTH-1:0] xq, yq;
    logic             uq;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        xq <= '0;
        yq <= '0;
        uq <= 1'b0;
      end else if (start) begin
        xq <= x;
        yq <= y;
        uq <= u;
      end
    end
    assign xs = xq;
    assign ys = yq;
    assign us = uq;
  end

  always_comb begin
    ex      = extend(xs, us);
    ey      = extend(ys, us);
    xh      = hi_part(ex);
    xl      = lo_part(ex);
    yh      = hi_part(ey);
    yl      = lo_part(ey);
    pp_c[0] = xh * yh;
    pp_c[1] = xh * yl;
    pp_c[2] = xl * yh;
    pp_c[3] = xl * yl;
  end

  if (LATENCY >= 3) begin : g_pp_reg
    logic [P-1:0] pp_q [4];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < 4; i++) pp_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < 4; i++) pp_q[i] <= pp_c[i];
      end
    end
    assign prod = sum_pp(pp_q[0], pp_q[1], pp_q[2], pp_q[3]);
  end else begin : g_pp_comb
    assign prod = sum_pp(pp_c[0], pp_c[1], pp_c[2], pp_c[3]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      z <= '0;
    else if (load) z <= prod;
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed bench for multiplier_pipe: a LATENCY=3 instance and a LATENCY=1 instance, WIDTH=32.
module tb_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, run1, u;
  logic [31:0] x, y;
  logic        stall, stall1;
  logic [63:0] z, z1;

  int n_tests = 0;
  int n_fail  = 0;

  multiplier_pipe #(.WIDTH(32), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .run(run), .u(u), .x(x), .y(y), .stall(stall), .z(z)
  );

  multiplier_pipe #(.WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .u(u), .x(x), .y(y), .stall(stall1), .z(z1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One full LATENCY=3 operation with run held through cycle 3; run drops mid-way through cycle 3.
  task automatic op(input logic [31:0] xv, input logic [31:0] yv, input logic uv,
                    input logic [63:0] exp, input string tag);
    @(negedge clk);
    x = xv; y = yv; u = uv; run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("%s_stall_c%0d", tag, c), 64'(stall), 64'd1);
      @(negedge clk);
    end
    #1 check({tag, "_stall_c3"}, 64'(stall), 64'd0);
    check({tag, "_z"}, z, exp);
    run = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; run1 = 1'b0; u = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    #1 check("rst_z", z, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    run = 1'b1;
    #1 check("rst_stall_run", 64'(stall), 64'd1);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    op(32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE, "umul");
    op(32'hFFFF_FFFF, 32'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, "smul");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "smin");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, "umax");
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_8000_0001, "smix");

    // Operand stability: x changes in cycle 1
    @(negedge clk);
    x = 32'd7; y = 32'd6; u = 1'b1; run = 1'b1;
    @(negedge clk);
    x = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1 check("hold_z", z, 64'd42);
    check("hold_stall_c3", 64'(stall), 64'd0);
    run = 1'b0;

    // Back-to-back: 5x3 then 4x4 with run held
    @(negedge clk);
    x = 32'd5; y = 32'd3; u = 1'b1; run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("b2b_a_stall_c%0d", c), 64'(stall), 64'd1);
      @(negedge clk);
    end
    #1 check("b2b_a_stall_c3", 64'(stall), 64'd0);
    check("b2b_a_z", z, 64'd15);
    x = 32'd4; y = 32'd4;
    for (int c = 4; c < 7; c++) begin
      @(negedge clk);
      #1 check($sformatf("b2b_b_stall_c%0d", c), 64'(stall), 64'd1);
      if (c == 5) check("b2b_z_held", z, 64'd15);
    end
    @(negedge clk);
    #1 check("b2b_b_stall_c7", 64'(stall), 64'd0);
    check("b2b_b_z", z, 64'd16);
    run = 1'b0;

    // Abort: 9x9 with run dropped in cycle 1, then 2x3 starting in cycle 2
    @(negedge clk);
    x = 32'd9; y = 32'd9; u = 1'b1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    #1 check("abort_stall", 64'(stall), 64'd0);
    check("abort_z_c1", z, 64'd16);
    op(32'd2, 32'd3, 1'b1, 64'd6, "after_abort");

    // Reset during cycle 1 of 9x9
    @(negedge clk);
    x = 32'd9; y = 32'd9; u = 1'b1; run = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1 check("mid_rst_z", z, 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op(32'd3, 32'd3, 1'b1, 64'd9, "post_rst");

    // LATENCY=1 instance
    @(negedge clk);
    x = 32'd3; y = 32'd3; u = 1'b1; run1 = 1'b1;
    #1 check("l1_stall_c0", 64'(stall1), 64'd1);
    @(negedge clk);
    #1 check("l1_stall_c1", 64'(stall1), 64'd0);
    check("l1_z", z1, 64'd9);
    run1 = 1'b0;
    @(negedge clk);
    x = 32'hFFFF_FFFD; y = 32'd5; u = 1'b0; run1 = 1'b1;
    #1 check("l1s_stall_c0", 64'(stall1), 64'd1);
    @(negedge clk);
    #1 check("l1s_stall_c1", 64'(stall1), 64'd0);
    check("l1s_z", z1, 64'hFFFF_FFFF_FFFF_FFF1);
    run1 = 1'b0;
    @(negedge clk);
    #1 check("l1_z_held", z1, 64'hFFFF_FFFF_FFFF_FFF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
